// File: rtl/sc_background_writer_pkg.sv
// sc_background_writer_pkg: shared game-block constants, FSM encoding and helpers
package sc_background_writer_pkg;
  localparam int NUM_ROWS = 8;
  localparam int ROW_IDX_W = 3;
  localparam int LINES_W = 4;
  typedef enum logic [2:0] {ST_IDLE, ST_MERGE, ST_SCAN, ST_SHIFT, ST_DONE} bw_state_e;
  function automatic logic [LINES_W-1:0] sat_inc(input logic [LINES_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/cc_row_shifter.sv
// cc_row_shifter: flags a full row r and builds the background with row r removed (upper rows drop by one)
module cc_row_shifter
  import sc_background_writer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [NUM_ROWS-1:0][W-1:0] rows_i,
  input  logic [ROW_IDX_W-1:0]       r_i,
  output logic [NUM_ROWS-1:0][W-1:0] rows_o,
  output logic                       full_o
);
  assign full_o = &rows_i[r_i];
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    if (g == NUM_ROWS - 1) begin : g_top
      assign rows_o[g] = (r_i > ROW_IDX_W'(g)) ? rows_i[g] : '0;
    end else begin : g_mid
      assign rows_o[g] = (r_i > ROW_IDX_W'(g)) ? rows_i[g] : rows_i[g+1];
    end
  end
endmodule

// File: rtl/sc_background_writer.sv
// sc_background_writer: ORs the moving piece into the background rows; full-row clearing and the
// Lines counter exist only when SC_BACKGROUND_WRITER_LINE_CLEAR_EN is defined
module sc_background_writer
  import sc_background_writer_pkg::*;
#(
  parameter int BACKGROUND_WRITER_DATAWIDTH = 8
) (
  input  logic                                   SC_BACKGROUND_WRITER_CLOCK_50,
  input  logic                                   SC_BACKGROUND_WRITER_RESET_InHigh,
  input  logic                                   SC_BACKGROUND_WRITER_Write_InLow,
  input  logic                                   SC_BACKGROUND_WRITER_Clear_InHigh,
  input  logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_POINT_InBUS_u0,
  input  logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_POINT_InBUS_u1,
  input  logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_POINT_InBUS_u2,
  input  logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_POINT_InBUS_u3,
  input  logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_POINT_InBUS_u4,
  input  logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_POINT_InBUS_u5,
  input  logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_POINT_InBUS_u6,
  input  logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_POINT_InBUS_u7,
  output logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_BACK_OutBUS_u0,
  output logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_BACK_OutBUS_u1,
  output logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_BACK_OutBUS_u2,
  output logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_BACK_OutBUS_u3,
  output logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_BACK_OutBUS_u4,
  output logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_BACK_OutBUS_u5,
  output logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_BACK_OutBUS_u6,
  output logic [BACKGROUND_WRITER_DATAWIDTH-1:0] SC_BACKGROUND_WRITER_BACK_OutBUS_u7,
  output logic                                   SC_BACKGROUND_WRITER_Busy_OutHigh,
  output logic                                   SC_BACKGROUND_WRITER_Done_OutHigh,
  output logic [LINES_W-1:0]                     SC_BACKGROUND_WRITER_Lines_OutBUS
);
  localparam int W = BACKGROUND_WRITER_DATAWIDTH;
`ifdef SC_BACKGROUND_WRITER_LINE_CLEAR_EN
  localparam bit LINE_CLEAR = 1'b1;
`else
  localparam bit LINE_CLEAR = 1'b0;
`endif
  logic clk, rst, clear, write_n, full;
  logic [NUM_ROWS-1:0][W-1:0] point, back_q, back_d, shifted;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic [ROW_IDX_W-1:0] r_q, r_d;
  bw_state_e state_q, state_d;
  assign clk = SC_BACKGROUND_WRITER_CLOCK_50;
  assign rst = SC_BACKGROUND_WRITER_RESET_InHigh;
  assign clear = SC_BACKGROUND_WRITER_Clear_InHigh;
  assign write_n = SC_BACKGROUND_WRITER_Write_InLow;
  assign point = {SC_BACKGROUND_WRITER_POINT_InBUS_u7, SC_BACKGROUND_WRITER_POINT_InBUS_u6,
                  SC_BACKGROUND_WRITER_POINT_InBUS_u5, SC_BACKGROUND_WRITER_POINT_InBUS_u4,
                  SC_BACKGROUND_WRITER_POINT_InBUS_u3, SC_BACKGROUND_WRITER_POINT_InBUS_u2,
                  SC_BACKGROUND_WRITER_POINT_InBUS_u1, SC_BACKGROUND_WRITER_POINT_InBUS_u0};
`ifdef SC_BACKGROUND_WRITER_LINE_CLEAR_EN
  cc_row_shifter #(.W(W)) u_shifter (
    .rows_i(back_q),
    .r_i   (r_q),
    .rows_o(shifted),
    .full_o(full)
  );
`else
  assign shifted = back_q;
  assign full = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      back_q  <= '0;
      lines_q <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      back_q  <= back_d;
      lines_q <= lines_d;
      r_q     <= r_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = write_n ? ST_IDLE : ST_MERGE;
      ST_MERGE: state_d = LINE_CLEAR ? ST_SCAN : ST_DONE;
      ST_SCAN:  state_d = full ? ST_SHIFT : (&r_q ? ST_DONE : ST_SCAN);
      ST_SHIFT: state_d = ST_SCAN;
      default:  state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end
  // r stays put after a shift so the row that dropped into slot r is checked too
  always_comb begin
    back_d  = back_q;
    lines_d = lines_q;
    r_d     = r_q;
    if (clear) begin
      back_d  = '0;
      lines_d = '0;
      r_d     = '0;
    end else if (state_q == ST_MERGE) begin
      back_d = back_q | point;
      r_d    = '0;
    end else if (state_q == ST_SCAN) begin
      r_d = (!full && !(&r_q)) ? r_q + 1'b1 : r_q;
    end else if (state_q == ST_SHIFT) begin
      back_d  = shifted;
      lines_d = sat_inc(lines_q);
    end
  end
  assign SC_BACKGROUND_WRITER_Busy_OutHigh = (state_q != ST_IDLE);
  assign SC_BACKGROUND_WRITER_Done_OutHigh = (state_q == ST_DONE);
  assign SC_BACKGROUND_WRITER_Lines_OutBUS = lines_q;
  assign SC_BACKGROUND_WRITER_BACK_OutBUS_u0 = back_q[0];
  assign SC_BACKGROUND_WRITER_BACK_OutBUS_u1 = back_q[1];
  assign SC_BACKGROUND_WRITER_BACK_OutBUS_u2 = back_q[2];
  assign SC_BACKGROUND_WRITER_BACK_OutBUS_u3 = back_q[3];
  assign SC_BACKGROUND_WRITER_BACK_OutBUS_u4 = back_q[4];
  assign SC_BACKGROUND_WRITER_BACK_OutBUS_u5 = back_q[5];
  assign SC_BACKGROUND_WRITER_BACK_OutBUS_u6 = back_q[6];
  assign SC_BACKGROUND_WRITER_BACK_OutBUS_u7 = back_q[7];
endmodule

// File: tb/tb_sc_background_writer.sv
// tb_sc_background_writer: random and directed merges checked against a row-list model of the background
module tb_sc_background_writer;
`ifdef SC_BACKGROUND_WRITER_LINE_CLEAR_EN
  localparam bit LCE = 1'b1;
`else
  localparam bit LCE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, write_n = 1'b1, clear = 1'b0;
  logic [7:0][7:0] point = '0, back;
  logic busy, done;
  logic [3:0] lines;
  logic [7:0] m_rows [8];
  int m_lines = 0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  sc_background_writer dut (
    .SC_BACKGROUND_WRITER_CLOCK_50     (clk),
    .SC_BACKGROUND_WRITER_RESET_InHigh (rst),
    .SC_BACKGROUND_WRITER_Write_InLow  (write_n),
    .SC_BACKGROUND_WRITER_Clear_InHigh (clear),
    .SC_BACKGROUND_WRITER_POINT_InBUS_u0(point[0]),
    .SC_BACKGROUND_WRITER_POINT_InBUS_u1(point[1]),
    .SC_BACKGROUND_WRITER_POINT_InBUS_u2(point[2]),
    .SC_BACKGROUND_WRITER_POINT_InBUS_u3(point[3]),
    .SC_BACKGROUND_WRITER_POINT_InBUS_u4(point[4]),
    .SC_BACKGROUND_WRITER_POINT_InBUS_u5(point[5]),
    .SC_BACKGROUND_WRITER_POINT_InBUS_u6(point[6]),
    .SC_BACKGROUND_WRITER_POINT_InBUS_u7(point[7]),
    .SC_BACKGROUND_WRITER_BACK_OutBUS_u0(back[0]),
    .SC_BACKGROUND_WRITER_BACK_OutBUS_u1(back[1]),
    .SC_BACKGROUND_WRITER_BACK_OutBUS_u2(back[2]),
    .SC_BACKGROUND_WRITER_BACK_OutBUS_u3(back[3]),
    .SC_BACKGROUND_WRITER_BACK_OutBUS_u4(back[4]),
    .SC_BACKGROUND_WRITER_BACK_OutBUS_u5(back[5]),
    .SC_BACKGROUND_WRITER_BACK_OutBUS_u6(back[6]),
    .SC_BACKGROUND_WRITER_BACK_OutBUS_u7(back[7]),
    .SC_BACKGROUND_WRITER_Busy_OutHigh (busy),
    .SC_BACKGROUND_WRITER_Done_OutHigh (done),
    .SC_BACKGROUND_WRITER_Lines_OutBUS (lines)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_row%0d", tag, i), back[i], m_rows[i]);
    check({tag, "_lines"}, lines, m_lines);
  endtask

  task automatic model_zero();
    for (int i = 0; i < 8; i++) m_rows[i] = '0;
    m_lines = 0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_zero();
  endtask

  // full rows vanish and everything above them falls; each costs one SHIFT plus one rescan
  task automatic do_write(input string tag, input logic [7:0][7:0] p, input bit poke);
    logic [7:0] keep [$];
    int nfull, exp_lat, lat, pulses;
    bit idle_seen;
    nfull = 0;
    keep = {};
    for (int i = 0; i < 8; i++) begin
      if (LCE && ((m_rows[i] | p[i]) == 8'hFF)) nfull++;
      else keep.push_back(m_rows[i] | p[i]);
    end
    for (int i = 0; i < 8; i++) m_rows[i] = (i < keep.size()) ? keep[i] : 8'h00;
    m_lines = (m_lines + nfull > 15) ? 15 : m_lines + nfull;
    exp_lat = LCE ? 9 + 2 * nfull : 1;
    @(negedge clk);
    point = p;
    write_n = 1'b0;
    @(negedge clk);
    check({tag, "_busy_merge"}, busy, 1'b1);
    write_n = 1'b1;
    lat = 0;
    pulses = 0;
    idle_seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      write_n = 1'b1;
      if (c == 1) point = {$urandom, $urandom};
      if (done) begin
        pulses++;
        if (lat == 0) lat = c;
      end
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
      if (poke && !done && $urandom_range(2) == 0) write_n = 1'b0;
    end
    check({tag, "_idle"}, idle_seen, 1'b1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_pulses"}, pulses, 1);
    check_state(tag);
  endtask

  function automatic logic [7:0][7:0] rand_point();
    logic [7:0][7:0] p;
    int k;
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(9);
      p[i] = (k == 0) ? 8'hFF : (k < 4) ? 8'($urandom) : 8'h00;
    end
    return p;
  endfunction

  initial begin
    logic [7:0][7:0] p;
    model_zero();
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_state("rst");
    @(negedge clk);
    rst = 1'b0;
    p = '0; p[3] = 8'h18;
    do_write("merge", p, 1'b0);
    do_clear();
    p = '0; p[0] = 8'hFE; p[1] = 8'h10;
    do_write("pre_lc", p, 1'b0);
    p = '0; p[0] = 8'h01;
    do_write("lc", p, 1'b1);
    do_clear();
    p = '0; p[0] = 8'hFF; p[1] = 8'hFF;
    do_write("dbl", p, 1'b1);
    do_clear();
    p = '1;
    do_write("sat1", p, 1'b1);
    do_write("sat2", p, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    model_zero();
    check("clrpri_busy", busy, 1'b0);
    check("clrpri_done", done, 1'b0);
    check_state("clrpri");
    clear = 1'b0;
    write_n = 1'b1;
    @(negedge clk);
    check("clrpri_busy2", busy, 1'b0);
    check("clrpri_done2", done, 1'b0);
    p = '0; p[0] = 8'hFF; p[2] = 8'h3C;
    @(negedge clk);
    point = p;
    write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    model_zero();
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_done", done, 1'b0);
    check_state("rstmid");
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) do_clear();
      do_write($sformatf("rnd%0d", n), rand_point(), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
